// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready/data channel between pipeline stages
interface pipe_stage_reg_if #(parameter int WIDTH = 32);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with stall/flush/bubble count; SKID_BUF_EN adds a skid entry
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(32'h0000_0013),
  parameter int               CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic             vld_q, vld_d, in_x, out_x;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SKID_BUF_EN
  logic             skv_q, skv_d, rdy_q, rdy_d;
  logic [WIDTH-1:0] skd_q, skd_d;
  // ready comes from a flop so out_ready never reaches in_ready combinationally
  assign up.ready = rdy_q & ~stall & ~flush & ~reset;
`else
  assign up.ready = ~reset & ~flush & ~stall & (~vld_q | dn.ready);
`endif
  assign dn.valid   = vld_q & ~stall;
  assign dn.data    = data_q;
  assign bubble_cnt = cnt_q;
  assign in_x       = up.valid & up.ready;
  assign out_x      = dn.valid & dn.ready;
  assign cnt_d      = cnt_clr ? '0 : (~dn.valid && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
`ifdef SKID_BUF_EN
    skv_d  = skv_q;
    skd_d  = skd_q;
    if (out_x) begin
      vld_d  = skv_q;
      data_d = skv_q ? skd_q : data_q;
      skv_d  = 1'b0;
    end
    if (in_x && vld_d) begin
      skv_d = 1'b1;
      skd_d = up.data;
    end else if (in_x) begin
      vld_d  = 1'b1;
      data_d = up.data;
    end
    if (flush) skv_d = 1'b0;
    rdy_d = ~skv_d;
`else
    if (out_x) vld_d = 1'b0;
    if (in_x) begin
      vld_d  = 1'b1;
      data_d = up.data;
    end
`endif
    if (flush) begin
      vld_d  = 1'b0;
      data_d = NOP_VALUE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= NOP_VALUE;
      cnt_q  <= '0;
`ifdef SKID_BUF_EN
      skv_q  <= 1'b0;
      rdy_q  <= 1'b1;
`endif
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
`ifdef SKID_BUF_EN
      skv_q  <= skv_d;
      skd_q  <= skd_d;
      rdy_q  <= rdy_d;
`endif
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scenario tasks plus an in-order scoreboard on the stage handshakes
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        reset, stall, flush, cnt_clr, cnt_clr2;
  logic [15:0] bubble_cnt;
  logic [3:0]  bubble_cnt2;
  logic [31:0] sb_exp;
  logic [31:0] sb[$];
  int          compared = 0;
  int          mismatched = 0;
  pipe_stage_reg_if #(.WIDTH(32)) up_if ();
  pipe_stage_reg_if #(.WIDTH(32)) dn_if ();
  pipe_stage_reg_if #(.WIDTH(32)) up2_if ();
  pipe_stage_reg_if #(.WIDTH(32)) dn2_if ();
  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .up(up_if), .dn(dn_if),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt)
  );
  pipe_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .up(up2_if), .dn(dn2_if),
    .stall(1'b0), .flush(1'b0), .cnt_clr(cnt_clr2), .bubble_cnt(bubble_cnt2)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (reset || flush) sb.delete();
    else begin
      if (dn_if.valid && dn_if.ready) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL sb_order: out_data=%h delivered, no payload expected", dn_if.data);
        end else begin
          sb_exp = sb.pop_front();
          if (dn_if.data !== sb_exp) begin
            mismatched++;
            $display("FAIL sb_order: out_data=%h expected %h", dn_if.data, sb_exp);
          end
        end
      end
      if (up_if.valid && up_if.ready) sb.push_back(up_if.data);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    compared++;
    if (up_if.ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %b want 0", up_if.ready); end
    reset = 1'b0;
    #1;
    compared += 5;
    if (dn_if.valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", dn_if.valid); end
    if (dn_if.data !== 32'h13) begin mismatched++; $display("FAIL reset_out_data: got %h want 00000013", dn_if.data); end
    if (bubble_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
    if (bubble_cnt2 !== 4'd0) begin mismatched++; $display("FAIL reset_cnt4: got %0d want 0", bubble_cnt2); end
    if (up_if.ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_in_ready: got %b want 1", up_if.ready); end
  endtask
  task automatic test_stream();
    logic [15:0] c = '0;
    dn_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = 32'hA0 + 32'(i);
      tick();
      if (i == 0) c = bubble_cnt;
      compared++;
      if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hA0 + 32'(i)) begin
        mismatched++;
        $display("FAIL stream_%0d: valid=%b data=%h want 1/%h", i, dn_if.valid, dn_if.data, 32'hA0 + 32'(i));
      end
    end
    up_if.valid = 1'b0;
    tick();
    compared += 2;
    if (bubble_cnt !== c) begin mismatched++; $display("FAIL stream_cnt: got %0d want %0d", bubble_cnt, c); end
    if (dn_if.valid !== 1'b0 || dn_if.data !== 32'hA7) begin
      mismatched++;
      $display("FAIL stream_drain: valid=%b data=%h want 0/000000a7", dn_if.valid, dn_if.data);
    end
  endtask
  task automatic test_backpressure();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'hDEAD;
    tick();
    up_if.data = 32'hBEEF;
    for (int k = 0; k < 3; k++) begin
      compared += 2;
      if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hDEAD) begin
        mismatched++;
        $display("FAIL hold_%0d: valid=%b data=%h want 1/0000dead", k, dn_if.valid, dn_if.data);
      end
`ifdef SKID_BUF_EN
      if (up_if.ready !== (k == 0)) begin mismatched++; $display("FAIL hold_ready_%0d: got %b want %b", k, up_if.ready, k == 0); end
      tick();
      if (k == 0) up_if.valid = 1'b0;
`else
      if (up_if.ready !== 1'b0) begin mismatched++; $display("FAIL hold_ready_%0d: got %b want 0", k, up_if.ready); end
      tick();
`endif
    end
    dn_if.ready = 1'b1;
    tick();
    up_if.valid = 1'b0;
    compared++;
    if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hBEEF) begin
      mismatched++;
      $display("FAIL release_second: valid=%b data=%h want 1/0000beef", dn_if.valid, dn_if.data);
    end
    tick();
    compared++;
    if (dn_if.valid !== 1'b0) begin mismatched++; $display("FAIL release_empty: got %b want 0", dn_if.valid); end
  endtask
  task automatic test_stall();
    logic [15:0] c;
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'h1234;
    tick();
    up_if.valid = 1'b0;
    c = bubble_cnt;
    stall = 1'b1;
    dn_if.ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      compared++;
      if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b0 || dn_if.data !== 32'h1234) begin
        mismatched++;
        $display("FAIL stall_%0d: valid=%b ready=%b data=%h want 0/0/00001234", k, dn_if.valid, up_if.ready, dn_if.data);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    compared += 2;
    if (bubble_cnt !== c + 16'd2) begin mismatched++; $display("FAIL stall_cnt: got %0d want %0d", bubble_cnt, c + 16'd2); end
    if (dn_if.valid !== 1'b1 || dn_if.data !== 32'h1234) begin
      mismatched++;
      $display("FAIL stall_release: valid=%b data=%h want 1/00001234", dn_if.valid, dn_if.data);
    end
    tick();
    compared++;
    if (dn_if.valid !== 1'b0) begin mismatched++; $display("FAIL stall_once: got %b want 0", dn_if.valid); end
  endtask
  task automatic test_flush();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'h7777;
    tick();
    up_if.data = 32'h5555;
    flush = 1'b1;
    #1;
    compared++;
    if (up_if.ready !== 1'b0 || dn_if.valid !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_cycle: ready=%b valid=%b want 0/1", up_if.ready, dn_if.valid);
    end
    tick();
    flush = 1'b0;
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    #1;
    compared++;
    if (dn_if.valid !== 1'b0 || dn_if.data !== 32'h13) begin
      mismatched++;
      $display("FAIL flush_nop: valid=%b data=%h want 0/00000013", dn_if.valid, dn_if.data);
    end
    tick();
    compared++;
    if (dn_if.valid !== 1'b0) begin mismatched++; $display("FAIL flush_dropped: got %b want 0", dn_if.valid); end
  endtask
  task automatic test_saturation();
    cnt_clr2 = 1'b1;
    tick();
    cnt_clr2 = 1'b0;
    compared++;
    if (bubble_cnt2 !== 4'd0) begin mismatched++; $display("FAIL sat_clear: got %0d want 0", bubble_cnt2); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14 || k == 15 || k == 20) begin
        compared++;
        if (bubble_cnt2 !== ((k == 14) ? 4'd14 : 4'd15)) begin
          mismatched++;
          $display("FAIL sat_%0d: got %0d want %0d", k, bubble_cnt2, (k == 14) ? 14 : 15);
        end
      end
    end
    cnt_clr2 = 1'b1;
    tick();
    cnt_clr2 = 1'b0;
    compared++;
    if (bubble_cnt2 !== 4'd0) begin mismatched++; $display("FAIL sat_reclear: got %0d want 0", bubble_cnt2); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    compared++;
    if (bubble_cnt !== 16'd0) begin mismatched++; $display("FAIL cnt_clr: got %0d want 0", bubble_cnt); end
  endtask
  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0; cnt_clr2 = 1'b0;
    up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b0;
    up2_if.valid = 1'b0; up2_if.data = '0; dn2_if.ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_saturation();
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("FAIL sb_leftover: %0d payloads never delivered", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
